m_store_buf: RTL

//  Store-side counterpart of the M-stage load data path. Checks store addresses (AdES),

---
 rtl/m_store_buf.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/m_store_buf.sv
// M-stage store buffer: AdES checking, sw/sh/sb lane encoding, DEPTH-entry FIFO drained over req/ack.
// Optional macro SB_MERGE_EN folds a store into the tail entry when it targets the same word.
module m_store_buf #(
    parameter int DEPTH = 2,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        store_i,
    input  logic [2:0]  dp_sel_i,
    input  logic [31:0] dwa_i,
    input  logic [31:0] rt_data_i,
    input  logic        ex_ov_dm_i,
    input  logic        flush_i,
    input  logic        load_i,
    input  logic [31:0] ld_addr_i,
    output logic        ex_ades_o,
    output logic        st_stall_o,
    output logic        ld_stall_o,
    output logic        bus_req_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_be_o,
    input  logic        bus_ack_i
);

    // Width codes shared with the load path (const.v: dp_w / dp_h / dp_b).
    localparam logic [2:0] DP_W = 3'd0;
    localparam logic [2:0] DP_H = 3'd1;
    localparam logic [2:0] DP_B = 3'd2;

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [29:0]   addr_q  [DEPTH];
    logic [31:0]   data_q  [DEPTH];
    logic [3:0]    be_q    [DEPTH];
    logic          valid_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;

    logic          misalign, outOfRange, timerNarrow, timerRo;
    logic [3:0]    newBe;
    logic [31:0]   newData;
    logic          full, push, pop, alloc, mergeHit;
    logic [AW-1:0] tailPtr;

    logic unused_ld;
    assign unused_ld = ^ld_addr_i[1:0];

    always_comb begin
        misalign    = ((dp_sel_i == DP_W) && (dwa_i[1:0] != 2'b00)) ||
                      ((dp_sel_i == DP_H) && dwa_i[0]);
        outOfRange  = !((dwa_i <= 32'h0000_2fff) ||
                        ((dwa_i >= 32'h0000_7f00) && (dwa_i <= 32'h0000_7f0b)) ||
                        ((dwa_i >= 32'h0000_7f10) && (dwa_i <= 32'h0000_7f1b)));
        timerNarrow = (dp_sel_i != DP_W) && (dwa_i >= 32'h0000_7f00);
        // COUNT registers of both timers are read-only.
        timerRo     = ((dwa_i >= 32'h0000_7f08) && (dwa_i <= 32'h0000_7f0b)) ||
                      ((dwa_i >= 32'h0000_7f18) && (dwa_i <= 32'h0000_7f1b));
        ex_ades_o   = store_i & (ex_ov_dm_i | misalign | outOfRange | timerNarrow | timerRo);
    end

    always_comb begin
        newBe   = 4'b1111;
        newData = rt_data_i;
        case (dp_sel_i)
            DP_H: begin
                newBe   = dwa_i[1] ? 4'b1100 : 4'b0011;
                newData = {2{rt_data_i[15:0]}};
            end
            DP_B: begin
                newBe   = 4'b0001 << dwa_i[1:0];
                newData = {4{rt_data_i[7:0]}};
            end
            default: ;
        endcase
    end

    assign tailPtr = wr_ptr_q - 1'b1;
    assign full    = (count_q == FULL);

`ifdef SB_MERGE_EN
    assign mergeHit = (count_q >= (AW+1)'(2)) && valid_q[tailPtr] &&
                      (addr_q[tailPtr] == dwa_i[31:2]);
`else
    assign mergeHit = 1'b0;
`endif

    assign st_stall_o = store_i & full & ~mergeHit;
    assign push       = store_i & ~ex_ades_o & ~flush_i & ~st_stall_o;
    assign alloc      = push & ~mergeHit;
    assign bus_req_o  = (count_q != '0);
    assign pop        = bus_req_o & bus_ack_i;

    assign bus_addr_o  = {addr_q[rd_ptr_q], 2'b00};
    assign bus_wdata_o = data_q[rd_ptr_q];
    assign bus_be_o    = be_q[rd_ptr_q];

    always_comb begin
        ld_stall_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i] == ld_addr_i[31:2])) ld_stall_o = load_i;
        end
    end

    // FIFO state: pop retires the head, alloc fills wr_ptr, a merge patches the tail in place.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i]  <= '0;
                data_q[i]  <= '0;
                be_q[i]    <= '0;
                valid_q[i] <= 1'b0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (pop) begin
                valid_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q          <= rd_ptr_q + 1'b1;
            end
            if (alloc) begin
                addr_q[wr_ptr_q]  <= dwa_i[31:2];
                data_q[wr_ptr_q]  <= newData;
                be_q[wr_ptr_q]    <= newBe;
                valid_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q          <= wr_ptr_q + 1'b1;
            end
            if (push && mergeHit) begin
                be_q[tailPtr] <= be_q[tailPtr] | newBe;
                for (int b = 0; b < 4; b++) begin
                    if (newBe[b]) data_q[tailPtr][8*b +: 8] <= newData[8*b +: 8];
                end
            end
            case ({alloc, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

endmodule
